// File: rtl/arm_pipe_pkg.sv
// Shared pipeline-control definitions: hazard FSM encoding, default sizing, dependency match helper.
// Combinational helpers only; nothing here holds state.
package arm_pipe_pkg;

   localparam int MAX_WAIT_DEF = 15;
   localparam int CNT_W_DEF    = 16;
   localparam int REG_W        = 4;

   localparam logic [0:0] ST_RUN      = 1'b0;
   localparam logic [0:0] ST_MEM_WAIT = 1'b1;

   typedef logic [REG_W-1:0] reg_id_t;

   // A consumer depends on dest if src1 matches, or src2 matches and src2 is actually read.
   function automatic logic dep_match(input reg_id_t s1,
                                      input reg_id_t s2,
                                      input logic    two,
                                      input reg_id_t dest);
      return (s1 == dest) | (two & (s2 == dest));
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// RAW dependency detection between ID and the EXE/MEM stages; purely combinational, zero latency.
// With forwarding only a load in EXE can stall; without it any pending writer in EXE or MEM stalls.
module hazard_detect
   import arm_pipe_pkg::*;
(
   input  logic    forward_en,
   input  logic    id_valid,
   input  reg_id_t src1,
   input  reg_id_t src2,
   input  logic    two_src,
   input  reg_id_t exe_dest,
   input  logic    exe_wb_en,
   input  logic    exe_mem_read,
   input  reg_id_t mem_dest,
   input  logic    mem_wb_en,
   output logic    raw_hz
);

   logic exe_match;
   logic mem_match;
   logic load_use;
   logic any_writer;

   assign exe_match  = dep_match(src1, src2, two_src, exe_dest);
   assign mem_match  = dep_match(src1, src2, two_src, mem_dest);

   assign load_use   = id_valid & exe_wb_en & exe_mem_read & exe_match;
   assign any_writer = id_valid & ((exe_wb_en & exe_match) | (mem_wb_en & mem_match));

   assign raw_hz     = forward_en ? load_use : any_writer;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW stall, memory-wait freeze, branch flush (deferred across a freeze).
// hazard/freeze_all/flush are same-cycle combinational; mem_timeout and stall_cnt update on the edge.
module hazard_ctrl
   import arm_pipe_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             forward_en,
   input  logic             id_valid,
   input  logic [3:0]       src1,
   input  logic [3:0]       src2,
   input  logic             two_src,
   input  logic [3:0]       exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_read,
   input  logic [3:0]       mem_dest,
   input  logic             mem_wb_en,
   input  logic             mem_access,
   input  logic             mem_ready,
   input  logic             branch_taken,
   output logic             hazard,
   output logic             freeze_all,
   output logic             flush,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int                WAIT_W   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_CAP = WAIT_W'(MAX_WAIT);

   logic [0:0]        state;
   logic [0:0]        state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_cnt_inc;
   logic              flush_pending;
   logic              raw_hz;
   logic              wait_enter;
   logic              wait_step;

   hazard_detect u_detect (
      .forward_en   (forward_en),
      .id_valid     (id_valid),
      .src1         (src1),
      .src2         (src2),
      .two_src      (two_src),
      .exe_dest     (exe_dest),
      .exe_wb_en    (exe_wb_en),
      .exe_mem_read (exe_mem_read),
      .mem_dest     (mem_dest),
      .mem_wb_en    (mem_wb_en),
      .raw_hz       (raw_hz)
   );

   assign freeze_all = mem_access & ~mem_ready;
   // A branch seen while frozen is remembered and applied once the freeze drops.
   assign flush      = (branch_taken | flush_pending) & ~freeze_all;
   assign hazard     = raw_hz & ~freeze_all & ~flush;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:      if (freeze_all) state_nxt = ST_MEM_WAIT;
         ST_MEM_WAIT: if (mem_ready)  state_nxt = ST_RUN;
         default:                     state_nxt = ST_RUN;
      endcase
   end

   assign wait_enter   = (state == ST_RUN) & freeze_all;
   assign wait_step    = (state == ST_MEM_WAIT) & freeze_all & (wait_cnt != WAIT_CAP);
   assign wait_cnt_inc = wait_cnt + WAIT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         if (wait_enter) begin
            wait_cnt <= '0;
         end else if (wait_step) begin
            wait_cnt <= wait_cnt_inc;
            // Sticky: the wait is never aborted, the flag just reports it ran long.
            if (wait_cnt_inc == WAIT_CAP) mem_timeout <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_pending <= 1'b0;
      end else if (flush) begin
         flush_pending <= 1'b0;
      end else if (branch_taken & freeze_all) begin
         flush_pending <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if ((hazard | freeze_all) && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl plus multi-cycle sequences for wait, flush, timeout, reset.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        forward_en, id_valid, two_src;
   logic [3:0]  src1, src2, exe_dest, mem_dest;
   logic        exe_wb_en, exe_mem_read, mem_wb_en;
   logic        mem_access, mem_ready, branch_taken;
   logic        hazard, freeze_all, flush, mem_timeout;
   logic [15:0] stall_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   hazard_ctrl #(.MAX_WAIT(15), .CNT_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .forward_en   (forward_en),
      .id_valid     (id_valid),
      .src1         (src1),
      .src2         (src2),
      .two_src      (two_src),
      .exe_dest     (exe_dest),
      .exe_wb_en    (exe_wb_en),
      .exe_mem_read (exe_mem_read),
      .mem_dest     (mem_dest),
      .mem_wb_en    (mem_wb_en),
      .mem_access   (mem_access),
      .mem_ready    (mem_ready),
      .branch_taken (branch_taken),
      .hazard       (hazard),
      .freeze_all   (freeze_all),
      .flush        (flush),
      .mem_timeout  (mem_timeout),
      .stall_cnt    (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       fwd, idv;
      logic [3:0] s1, s2;
      logic       two;
      logic [3:0] ed;
      logic       ewb, emr;
      logic [3:0] md;
      logic       mwb, acc, rdy, br;
      logic       e_hz, e_fz, e_fl, e_st;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clr_in();
      forward_en = 1'b1; id_valid = 1'b0; src1 = 4'd0; src2 = 4'd0; two_src = 1'b0;
      exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
      mem_dest = 4'd0; mem_wb_en = 1'b0;
      mem_access = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clr_in();
      tick();
      rst = 1'b0;
   endtask

   function automatic vec_t mk(logic fwd, logic idv, logic [3:0] s1, logic [3:0] s2, logic two,
                               logic [3:0] ed, logic ewb, logic emr, logic [3:0] md, logic mwb,
                               logic acc, logic rdy, logic br,
                               logic hz, logic fz, logic fl, logic st);
      vec_t v;
      v.fwd = fwd; v.idv = idv; v.s1 = s1; v.s2 = s2; v.two = two;
      v.ed = ed; v.ewb = ewb; v.emr = emr; v.md = md; v.mwb = mwb;
      v.acc = acc; v.rdy = rdy; v.br = br;
      v.e_hz = hz; v.e_fz = fz; v.e_fl = fl; v.e_st = st;
      return v;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //          fwd idv s1 s2 two ed ewb emr md mwb acc rdy br   hz fz fl state_after
      vecs[0]  = mk(1, 1, 3, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0); // load-use src1
      vecs[1]  = mk(1, 1, 3, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0); // not a load
      vecs[2]  = mk(0, 1, 0, 5, 1, 0, 0, 0, 5, 1, 0, 0, 0,   1, 0, 0, 0); // no fwd, MEM src2
      vecs[3]  = mk(0, 1, 0, 5, 0, 0, 0, 0, 5, 1, 0, 0, 0,   0, 0, 0, 0); // src2 unused
      vecs[4]  = mk(0, 1, 7, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0); // no fwd, EXE ALU
      vecs[5]  = mk(1, 1, 5, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0,   0, 0, 0, 0); // forwarded from MEM
      vecs[6]  = mk(1, 0, 3, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0); // bubble in ID
      vecs[7]  = mk(1, 1, 3, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0); // load without wb
      vecs[8]  = mk(1, 1, 1, 9, 1, 9, 1, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0); // load-use src2
      vecs[9]  = mk(1, 1, 3, 0, 0, 3, 1, 1, 0, 0, 0, 0, 1,   0, 0, 1, 0); // branch beats load-use
      vecs[10] = mk(1, 1, 3, 0, 0, 3, 1, 1, 0, 0, 1, 1, 0,   1, 0, 0, 0); // zero-wait access
      vecs[11] = mk(1, 1, 3, 0, 0, 3, 1, 1, 0, 0, 1, 0, 0,   0, 1, 0, 1); // freeze masks hazard
      vecs[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0); // ready ends the wait

      do_reset();
      chk("reset_hazard", hazard, 0);
      chk("reset_freeze", freeze_all, 0);
      chk("reset_flush", flush, 0);
      chk("reset_timeout", mem_timeout, 0);
      chk("reset_stall_cnt", stall_cnt, 0);
      chk("reset_state", dut.state, 0);

      for (int i = 0; i < 13; i++) begin
         forward_en = vecs[i].fwd; id_valid = vecs[i].idv;
         src1 = vecs[i].s1; src2 = vecs[i].s2; two_src = vecs[i].two;
         exe_dest = vecs[i].ed; exe_wb_en = vecs[i].ewb; exe_mem_read = vecs[i].emr;
         mem_dest = vecs[i].md; mem_wb_en = vecs[i].mwb;
         mem_access = vecs[i].acc; mem_ready = vecs[i].rdy; branch_taken = vecs[i].br;
         #4;
         chk($sformatf("vec%0d_hazard", i), hazard, vecs[i].e_hz);
         chk($sformatf("vec%0d_freeze", i), freeze_all, vecs[i].e_fz);
         chk($sformatf("vec%0d_flush", i), flush, vecs[i].e_fl);
         tick();
         chk($sformatf("vec%0d_state", i), dut.state, vecs[i].e_st);
      end
      // hazards in vectors 0,2,4,8,10 plus one freeze cycle
      clr_in();
      chk("table_stall_cnt", stall_cnt, 6);

      // Memory wait: four frozen cycles, then ready.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         mem_access = 1'b1; mem_ready = 1'b0;
         #4;
         chk($sformatf("wait%0d_freeze", i), freeze_all, 1);
         chk($sformatf("wait%0d_hazard", i), hazard, 0);
         tick();
      end
      mem_ready = 1'b1;
      #4;
      chk("wait_done_freeze", freeze_all, 0);
      chk("wait_done_hazard", hazard, 0);
      tick();
      clr_in();
      chk("wait_state_run", dut.state, 0);
      chk("wait_stall_cnt", stall_cnt, 4);

      // Deferred flush: branch pulsed during the freeze.
      do_reset();
      mem_access = 1'b1; branch_taken = 1'b1;
      #4;
      chk("dflush_c0", flush, 0);
      tick();
      branch_taken = 1'b0;
      for (int i = 1; i < 3; i++) begin
         #4;
         chk($sformatf("dflush_c%0d", i), flush, 0);
         tick();
      end
      mem_ready = 1'b1;
      #4;
      chk("dflush_release", flush, 1);
      tick();
      clr_in();
      #4;
      chk("dflush_after", flush, 0);
      tick();

      // Timeout: 20 frozen cycles; flag appears after the 16th edge.
      do_reset();
      mem_access = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         #4;
         chk($sformatf("tmo_edge%0d", i), mem_timeout, (i >= 16) ? 1 : 0);
         tick();
      end
      chk("tmo_stall_cnt", stall_cnt, 20);
      mem_ready = 1'b1;
      tick();
      clr_in();
      tick();
      chk("tmo_sticky", mem_timeout, 1);
      chk("tmo_stall_hold", stall_cnt, 20);
      rst = 1'b1;
      #1;
      chk("tmo_rst_clears", mem_timeout, 0);
      tick();
      rst = 1'b0;

      // Reset mid-wait with a flush pending.
      clr_in();
      tick();
      mem_access = 1'b1; branch_taken = 1'b1;
      tick();
      branch_taken = 1'b0;
      tick();
      tick();
      chk("midrst_in_wait", dut.state, 1);
      rst = 1'b1;
      #1;
      chk("midrst_state", dut.state, 0);
      chk("midrst_stall_cnt", stall_cnt, 0);
      clr_in();
      tick();
      rst = 1'b0;
      #4;
      chk("midrst_no_flush0", flush, 0);
      tick();
      #4;
      chk("midrst_no_flush1", flush, 0);
      chk("midrst_state_run", dut.state, 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
